// File: rtl/router_vc_pipe.sv
// router_vc_pipe: per-port, per-VC flit FIFOs with round-robin VC arbitration.
// Each input port drains to the same-index output port; outputs are registered.
//
// Ports:
//   clk    rising-edge clock
//   RST_   asynchronous active-low reset
//   IDATA  input flits, port p at [p*DATA_W +: DATA_W]
//   IVALID input flit valid, one bit per port
//   IVCH   input VC index, port p at [p*VCW +: VCW]
//   ORDY   space available per (port,VC), bit p*NVC+v
//   OACK   one-cycle pulse when a flit leaves FIFO (p,v)
//   OERR   sticky overflow / bad-VC flag per port
//   ODATA  registered output flits
//   OVALID registered output valid
//   OVCH   registered output VC
//   IRDY   downstream ready per (port,VC)
module router_vc_pipe #(
  parameter int NPORTS = 5,
  parameter int NVC    = 2,
  parameter int DATA_W = 35,
  parameter int DEPTH  = 4,
  localparam int VCW   = (NVC > 1) ? $clog2(NVC) : 1
) (
  input  logic                     clk,
  input  logic                     RST_,
  input  logic [NPORTS*DATA_W-1:0] IDATA,
  input  logic [NPORTS-1:0]        IVALID,
  input  logic [NPORTS*VCW-1:0]    IVCH,
  output logic [NPORTS*NVC-1:0]    ORDY,
  output logic [NPORTS*NVC-1:0]    OACK,
  output logic [NPORTS-1:0]        OERR,
  output logic [NPORTS*DATA_W-1:0] ODATA,
  output logic [NPORTS-1:0]        OVALID,
  output logic [NPORTS*VCW-1:0]    OVCH,
  input  logic [NPORTS*NVC-1:0]    IRDY
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_W-1:0] mem [NPORTS][NVC][DEPTH];
  logic [AW-1:0]     wr_ptr [NPORTS][NVC];
  logic [AW-1:0]     rd_ptr [NPORTS][NVC];
  logic [CW-1:0]     cnt [NPORTS][NVC];
  logic [VCW-1:0]    rr [NPORTS];

  logic [VCW-1:0]    ivc [NPORTS];
  logic              push [NPORTS][NVC];
  logic              pop [NPORTS][NVC];
  logic [NPORTS-1:0] err_set;
  logic [NPORTS-1:0] gnt_vld;
  logic [VCW-1:0]    gnt_vc [NPORTS];

  // Push qualification: a full FIFO rejects even if it pops this cycle.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      ivc[p] = IVCH[p*VCW +: VCW];
      err_set[p] = IVALID[p] && (int'(ivc[p]) >= NVC);
      for (int v = 0; v < NVC; v++) begin
        push[p][v] = IVALID[p] && (int'(ivc[p]) == v)
                     && (cnt[p][v] != FULL);
        if (IVALID[p] && (int'(ivc[p]) == v)
            && (cnt[p][v] == FULL))
          err_set[p] = 1'b1;
      end
    end
  end

  // Round-robin search starting one past the last granted VC.
  always_comb begin
    int idx;
    idx = 0;
    for (int p = 0; p < NPORTS; p++) begin
      gnt_vld[p] = 1'b0;
      gnt_vc[p]  = '0;
      for (int k = 1; k <= NVC; k++) begin
        idx = (int'(rr[p]) + k) % NVC;
        if (!gnt_vld[p] && (cnt[p][idx] != '0)
            && IRDY[p*NVC+idx]) begin
          gnt_vld[p] = 1'b1;
          gnt_vc[p]  = VCW'(idx);
        end
      end
      for (int v = 0; v < NVC; v++)
        pop[p][v] = gnt_vld[p] && (int'(gnt_vc[p]) == v);
    end
  end

  always_comb begin
    ORDY = '0;
    for (int p = 0; p < NPORTS; p++)
      for (int v = 0; v < NVC; v++)
        ORDY[p*NVC+v] = RST_ && (cnt[p][v] != FULL);
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++)
      for (int v = 0; v < NVC; v++)
        if (push[p][v])
          mem[p][v][wr_ptr[p][v]] <= IDATA[p*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      for (int p = 0; p < NPORTS; p++) begin
        rr[p] <= '0;
        for (int v = 0; v < NVC; v++) begin
          cnt[p][v]    <= '0;
          wr_ptr[p][v] <= '0;
          rd_ptr[p][v] <= '0;
        end
      end
      OERR   <= '0;
      ODATA  <= '0;
      OVALID <= '0;
      OVCH   <= '0;
      OACK   <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (err_set[p])
          OERR[p] <= 1'b1;
        OVALID[p] <= gnt_vld[p];
        if (gnt_vld[p]) begin
          rr[p] <= gnt_vc[p];
          OVCH[p*VCW +: VCW] <= gnt_vc[p];
          ODATA[p*DATA_W +: DATA_W] <=
            mem[p][gnt_vc[p]][rd_ptr[p][gnt_vc[p]]];
        end
        for (int v = 0; v < NVC; v++) begin
          OACK[p*NVC+v] <= pop[p][v];
          if (push[p][v])
            wr_ptr[p][v] <= wr_ptr[p][v] + AW'(1);
          if (pop[p][v])
            rd_ptr[p][v] <= rd_ptr[p][v] + AW'(1);
          case ({push[p][v], pop[p][v]})
            2'b10:   cnt[p][v] <= cnt[p][v] + CW'(1);
            2'b01:   cnt[p][v] <= cnt[p][v] - CW'(1);
            default: cnt[p][v] <= cnt[p][v];
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_router_vc_pipe.sv
// tb_router_vc_pipe: directed bench for router_vc_pipe.
// Scoreboard holds expected flits per (port,VC); a negedge monitor pops them.
module tb_router_vc_pipe;

  localparam int NP = 5;
  localparam int NV = 2;
  localparam int DW = 35;
  localparam int VW = 1;

  logic              clk;
  logic              RST_;
  logic [NP*DW-1:0]  IDATA;
  logic [NP-1:0]     IVALID;
  logic [NP*VW-1:0]  IVCH;
  logic [NP*NV-1:0]  ORDY;
  logic [NP*NV-1:0]  OACK;
  logic [NP-1:0]     OERR;
  logic [NP*DW-1:0]  ODATA;
  logic [NP-1:0]     OVALID;
  logic [NP*VW-1:0]  OVCH;
  logic [NP*NV-1:0]  IRDY;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] sbq [NP*NV][$];

  router_vc_pipe dut (
    .clk(clk), .RST_(RST_),
    .IDATA(IDATA), .IVALID(IVALID), .IVCH(IVCH),
    .ORDY(ORDY), .OACK(OACK), .OERR(OERR),
    .ODATA(ODATA), .OVALID(OVALID), .OVCH(OVCH),
    .IRDY(IRDY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input int p, input int vc,
                          input logic [DW-1:0] d, input bit acc);
    IDATA[p*DW +: DW] = d;
    IVCH[p*VW +: VW]  = VW'(vc);
    IVALID[p] = 1'b1;
    if (acc) sbq[p*NV+vc].push_back(d);
    cycle();
    IVALID[p] = 1'b0;
  endtask

  task automatic sb_flush();
    for (int k = 0; k < NP*NV; k++) sbq[k].delete();
  endtask

  task automatic sb_drained();
    for (int k = 0; k < NP*NV; k++)
      chk($sformatf("sb_empty%0d", k), 64'(sbq[k].size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (RST_) begin
      for (int p = 0; p < NP; p++) begin
        logic [NV-1:0] eack;
        int vc;
        vc = int'(OVCH[p*VW +: VW]);
        eack = OVALID[p] ? NV'(1 << vc) : '0;
        chk($sformatf("oack_p%0d", p), 64'(OACK[p*NV +: NV]),
            64'(eack));
        if (OVALID[p]) begin
          chk($sformatf("expected_p%0dv%0d", p, vc),
              64'(sbq[p*NV+vc].size() > 0), 64'd1);
          if (sbq[p*NV+vc].size() > 0)
            chk($sformatf("data_p%0dv%0d", p, vc),
                64'(ODATA[p*DW +: DW]),
                64'(sbq[p*NV+vc].pop_front()));
        end
      end
    end
  end

  initial begin
    RST_ = 1'b0;
    IDATA = '0;
    IVALID = '0;
    IVCH = '0;
    IRDY = '1;
    #2;
    chk("rst_ordy", 64'(ORDY), 64'd0);
    chk("rst_ovalid", 64'(OVALID), 64'd0);
    chk("rst_oack", 64'(OACK), 64'd0);
    chk("rst_oerr", 64'(OERR), 64'd0);
    chk("rst_odata", 64'(ODATA[DW-1:0]), 64'd0);
    cycle();
    cycle();
    RST_ = 1'b1;
    #1;
    chk("rel_ordy", 64'(ORDY), 64'h3FF);

    // latency: one edge to store, next edge to output
    push_one(0, 1, 35'h1_2345_6789, 1'b1);
    chk("lat_early", 64'(OVALID[0]), 64'd0);
    cycle();
    chk("lat_valid", 64'(OVALID[0]), 64'd1);
    chk("lat_vc", 64'(OVCH[0]), 64'd1);
    chk("lat_data", 64'(ODATA[DW-1:0]), 64'h1_2345_6789);
    chk("lat_ack", 64'(OACK[1:0]), 64'b10);
    cycle();
    chk("lat_ack_off", 64'(OACK[1:0]), 64'b00);
    chk("lat_vld_off", 64'(OVALID[0]), 64'd0);

    // full / overflow on (2,0)
    IRDY[4] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("full_ordy_pre", 64'(ORDY[4]), 64'd1);
      push_one(2, 0, DW'(35'h2_0000_0000 + i), 1'b1);
    end
    chk("full_ordy", 64'(ORDY[4]), 64'd0);
    chk("full_oerr0", 64'(OERR), 64'd0);
    push_one(2, 0, 35'h7_DEAD_BEEF, 1'b0);
    chk("ovf_oerr", 64'(OERR), 64'b00100);
    IRDY[4] = 1'b1;
    repeat (6) cycle();
    chk("ovf_ordy_back", 64'(ORDY[4]), 64'd1);
    sb_drained();

    // round-robin on port 3
    IRDY[7:6] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      push_one(3, 0, DW'(35'h3_0000_0000 + i), 1'b1);
      push_one(3, 1, DW'(35'h3_1000_0000 + i), 1'b1);
    end
    IRDY[7:6] = 2'b11;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk($sformatf("rr_vld%0d", i), 64'(OVALID[3]), 64'd1);
      chk($sformatf("rr_vc%0d", i), 64'(OVCH[3]),
          64'((i % 2 == 0) ? 1 : 0));
    end
    cycle();
    chk("rr_idle", 64'(OVALID[3]), 64'd0);
    sb_drained();

    // backpressure on (1,1)
    IRDY[3:2] = 2'b00;
    push_one(1, 0, 35'h4_AAAA_0000, 1'b1);
    push_one(1, 1, 35'h4_BBBB_0000, 1'b1);
    push_one(1, 0, 35'h4_AAAA_0001, 1'b1);
    push_one(1, 1, 35'h4_BBBB_0001, 1'b1);
    IRDY[2] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("bp_vld", 64'(OVALID[1]), 64'd1);
      chk("bp_vc0", 64'(OVCH[1]), 64'd0);
    end
    cycle();
    chk("bp_stall", 64'(OVALID[1]), 64'd0);
    IRDY[3] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("bp_vld1", 64'(OVALID[1]), 64'd1);
      chk("bp_vc1", 64'(OVCH[1]), 64'd1);
    end
    cycle();
    sb_drained();

    // push into full (1,0) while it pops
    IRDY[2] = 1'b0;
    for (int i = 0; i < 4; i++)
      push_one(1, 0, DW'(35'h5_0000_0000 + i), 1'b1);
    chk("pp_full", 64'(ORDY[2]), 64'd0);
    IRDY[2] = 1'b1;
    push_one(1, 0, 35'h5_FFFF_FFFF, 1'b0);
    chk("pp_vld", 64'(OVALID[1]), 64'd1);
    chk("pp_data", 64'(ODATA[DW +: DW]), 64'h5_0000_0000);
    chk("pp_oerr", 64'(OERR), 64'b00110);
    repeat (6) cycle();
    sb_drained();

    // reset mid-stream discards buffered flits
    IRDY[8] = 1'b0;
    push_one(4, 0, 35'h6_0000_0001, 1'b0);
    push_one(4, 0, 35'h6_0000_0002, 1'b0);
    push_one(4, 1, 35'h6_1111_1111, 1'b1);
    cycle();
    chk("mid_vld", 64'(OVALID[4]), 64'd1);
    #2;
    RST_ = 1'b0;
    sb_flush();
    #1;
    chk("mid_rst_vld", 64'(OVALID), 64'd0);
    chk("mid_rst_ack", 64'(OACK), 64'd0);
    chk("mid_rst_ordy", 64'(ORDY), 64'd0);
    chk("mid_rst_err", 64'(OERR), 64'd0);
    cycle();
    RST_ = 1'b1;
    IRDY = '1;
    #1;
    chk("mid_rel_ordy", 64'(ORDY), 64'h3FF);
    repeat (8) cycle();
    chk("mid_quiet", 64'(OVALID), 64'd0);
    sb_drained();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
